// File: rtl/gc_nch.sv
// N-channel good-completion tracker: per-lbuf DW accounting, round-robin gc update arbitration, done strobes.
// Optional coalesced interrupt (data_rdy) is built only when COL_IRQ_EN is defined.
module gc_nch #(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int HOLD = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  rd_lbuf,
  input  logic [63:0]     lbuf_addr,
  input  logic [31:0]     lbuf_len,
  input  logic [NCH-1:0]  cpl_rcved,
  input  logic [9:0]      cpl_dws,
  output logic [63:0]     gc_addr,
  output logic [CHW-1:0]  gc_ch,
  output logic            gc_updt,
  input  logic            gc_updt_ack,
  output logic [NCH-1:0]  wt_lbuf,
  output logic [NCH-1:0]  cpl_err,
  output logic            data_rdy
);

  // Handshake: gc_updt/gc_ch/gc_addr hold steady until a cycle with gc_updt && gc_updt_ack;
  // gc_updt is low the cycle after that transfer.
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_REQ, ST_GNT} st_e;

  localparam logic [CHW:0]   NCH_W  = (CHW+1)'(NCH);
  localparam logic [CHW-1:0] CH_MAX = CHW'(NCH-1);

  st_e         st_q   [NCH];
  st_e         st_d   [NCH];
  logic [63:0] addr_q [NCH];
  logic [63:0] addr_d [NCH];
  logic [30:0] tgt_q  [NCH];
  logic [30:0] tgt_d  [NCH];
  logic [30:0] cnt_q  [NCH];
  logic [30:0] cnt_d  [NCH];
  logic [NCH-1:0] err_q, err_d, wt_q, wt_d;
  logic           gc_updt_q, gc_updt_d;
  logic [CHW-1:0] gc_ch_q, gc_ch_d, rr_q, rr_d;
  logic [63:0]    gc_addr_q, gc_addr_d;

  logic           rd_hit, cpl_hit, arb_hit;
  logic [CHW-1:0] rd_idx, cpl_idx, arb_idx;
  logic [CHW:0]   arb_sum;
  logic [30:0]    dws_ext, add, sat;
  logic [31:0]    sum;

  // Lowest set bit wins on both one-hot pulse buses.
  always_comb begin
    rd_hit  = 1'b0;
    rd_idx  = '0;
    cpl_hit = 1'b0;
    cpl_idx = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (rd_lbuf[i]) begin
        rd_hit = 1'b1;
        rd_idx = CHW'(i);
      end
      if (cpl_rcved[i]) begin
        cpl_hit = 1'b1;
        cpl_idx = CHW'(i);
      end
    end
  end

  // First requesting channel at or after the round-robin pointer.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    arb_sum = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      arb_sum = {1'b0, rr_q} + (CHW+1)'(k);
      if (arb_sum >= NCH_W) arb_sum = arb_sum - NCH_W;
      if (st_q[arb_sum[CHW-1:0]] == ST_REQ) begin
        arb_hit = 1'b1;
        arb_idx = arb_sum[CHW-1:0];
      end
    end
  end

  assign dws_ext = (cpl_dws == 10'd0) ? 31'd1024 : {21'd0, cpl_dws};

  always_comb begin
    err_d = err_q;
    wt_d  = '0;
    add   = '0;
    sum   = '0;
    sat   = '0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i]   = st_q[i];
      addr_d[i] = addr_q[i];
      tgt_d[i]  = tgt_q[i];
      cnt_d[i]  = cnt_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (rd_hit && rd_idx == CHW'(i)) begin
            st_d[i]   = ST_ARMED;
            addr_d[i] = lbuf_addr;
            tgt_d[i]  = {1'b0, lbuf_len[31:2]} + {30'd0, |lbuf_len[1:0]};
            cnt_d[i]  = '0;
          end
          if (cpl_hit && cpl_idx == CHW'(i)) err_d[i] = 1'b1;
        end
        ST_ARMED: begin
          // A zero-length lbuf falls straight through to REQ since cnt is already 0.
          add = (cpl_hit && cpl_idx == CHW'(i)) ? dws_ext : 31'd0;
          sum = {1'b0, cnt_q[i]} + {1'b0, add};
          sat = sum[31] ? '1 : sum[30:0];
          cnt_d[i] = sat;
          if (sat >= tgt_q[i]) st_d[i] = ST_REQ;
          if (sat > tgt_q[i]) err_d[i] = 1'b1;
        end
        ST_REQ: begin
          if (cpl_hit && cpl_idx == CHW'(i)) err_d[i] = 1'b1;
          if (!gc_updt_q && arb_hit && arb_idx == CHW'(i)) st_d[i] = ST_GNT;
        end
        default: begin
          if (cpl_hit && cpl_idx == CHW'(i)) err_d[i] = 1'b1;
          if (gc_updt_ack) begin
            st_d[i] = ST_IDLE;
            wt_d[i] = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    gc_updt_d = gc_updt_q;
    gc_ch_d   = gc_ch_q;
    gc_addr_d = gc_addr_q;
    rr_d      = rr_q;
    if (gc_updt_q) begin
      if (gc_updt_ack) begin
        gc_updt_d = 1'b0;
        rr_d      = (gc_ch_q == CH_MAX) ? '0 : gc_ch_q + 1'b1;
      end
    end else if (arb_hit) begin
      gc_updt_d = 1'b1;
      gc_ch_d   = arb_idx;
      gc_addr_d = addr_q[arb_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= ST_IDLE;
        addr_q[i] <= '0;
        tgt_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
      err_q     <= '0;
      wt_q      <= '0;
      gc_updt_q <= 1'b0;
      gc_ch_q   <= '0;
      gc_addr_q <= '0;
      rr_q      <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= st_d[i];
        addr_q[i] <= addr_d[i];
        tgt_q[i]  <= tgt_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      err_q     <= err_d;
      wt_q      <= wt_d;
      gc_updt_q <= gc_updt_d;
      gc_ch_q   <= gc_ch_d;
      gc_addr_q <= gc_addr_d;
      rr_q      <= rr_d;
    end
  end

  assign gc_updt = gc_updt_q;
  assign gc_ch   = gc_ch_q;
  assign gc_addr = gc_addr_q;
  assign wt_lbuf = wt_q;
  assign cpl_err = err_q;

`ifdef COL_IRQ_EN
  localparam int HW = $clog2(HOLD + 1);

  logic          pend_q, pend_d, data_rdy_q, fire;
  logic [HW-1:0] hold_q, hold_d;

  // Closes arriving while the hold counter runs merge into one later pulse.
  always_comb begin
    fire   = pend_q && (hold_q == '0);
    pend_d = (pend_q && !fire) || (|wt_q);
    hold_d = fire ? HW'(HOLD) : ((hold_q != '0) ? hold_q - 1'b1 : hold_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      hold_q     <= '0;
      data_rdy_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      data_rdy_q <= fire;
    end
  end

  assign data_rdy = data_rdy_q;
`else
  // Constant 0; HOLD only matters when coalescing is built.
  assign data_rdy = (HOLD < 0);
`endif

endmodule

// File: tb/tb_gc_nch.sv
// Directed bench for gc_nch: scoreboard queues of expected gc grants and wt_lbuf strobes, checked by a monitor.
module tb_gc_nch;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic            clk, rst_n;
  logic [NCH-1:0]  rd_lbuf, cpl_rcved, wt_lbuf, cpl_err;
  logic [63:0]     lbuf_addr, gc_addr;
  logic [31:0]     lbuf_len;
  logic [9:0]      cpl_dws;
  logic [CHW-1:0]  gc_ch;
  logic            gc_updt, gc_updt_ack, data_rdy;

  gc_nch #(.NCH(NCH), .CHW(CHW), .HOLD(64)) dut (
    .clk(clk), .rst_n(rst_n), .rd_lbuf(rd_lbuf), .lbuf_addr(lbuf_addr), .lbuf_len(lbuf_len),
    .cpl_rcved(cpl_rcved), .cpl_dws(cpl_dws), .gc_addr(gc_addr), .gc_ch(gc_ch), .gc_updt(gc_updt),
    .gc_updt_ack(gc_updt_ack), .wt_lbuf(wt_lbuf), .cpl_err(cpl_err), .data_rdy(data_rdy)
  );

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int ack_wait = 0;
  int dr_cnt = 0;
  logic [65:0]    exp_q[$];
  logic [NCH-1:0] wexp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // driver tasks: called at a negedge, hold inputs for one cycle
  task automatic arm(input int ch, input logic [63:0] a, input logic [31:0] len);
    rd_lbuf   = 4'b0001 << ch;
    lbuf_addr = a;
    lbuf_len  = len;
    @(negedge clk);
    rd_lbuf = '0;
  endtask

  task automatic cpl(input int ch, input logic [9:0] dws);
    cpl_rcved = 4'b0001 << ch;
    cpl_dws   = dws;
    @(negedge clk);
    cpl_rcved = '0;
  endtask

  task automatic push_gc(input int ch, input logic [63:0] a);
    exp_q.push_back({2'(ch), a});
    wexp_q.push_back(4'b0001 << ch);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0 || gc_updt) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) timeout_fail(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_updt(input int ch, input string name);
    int n;
    n = 0;
    while (!(gc_updt && gc_ch == 2'(ch)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout_fail(name);
  endtask

  // ack responder: acks after ack_delay cycles of gc_updt
  initial begin
    gc_updt_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (gc_updt && !gc_updt_ack && rst_n) begin
        if (ack_wait >= ack_delay) begin
          gc_updt_ack = 1'b1;
          ack_wait = 0;
        end else ack_wait++;
      end else begin
        gc_updt_ack = 1'b0;
        if (!gc_updt) ack_wait = 0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [65:0]    e;
    logic [NCH-1:0] w;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (gc_updt && gc_updt_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL gc_unexpected actual=ch%0d required=none", gc_ch);
          end else begin
            e = exp_q.pop_front();
            check("gc_ch", 64'(gc_ch), 64'(e[65:64]));
            check("gc_addr", gc_addr, e[63:0]);
          end
        end
        if (wt_lbuf != '0) begin
          if (wexp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wt_unexpected actual=%b required=none", wt_lbuf);
          end else begin
            w = wexp_q.pop_front();
            check("wt_lbuf", 64'(wt_lbuf), 64'(w));
          end
        end
        if (data_rdy) dr_cnt++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rd_lbuf = '0;
    cpl_rcved = '0;
    lbuf_addr = '0;
    lbuf_len = '0;
    cpl_dws = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_gc_updt", 64'(gc_updt), 64'd0);
    check("rst_gc_ch", 64'(gc_ch), 64'd0);
    check("rst_gc_addr", gc_addr, 64'd0);
    check("rst_wt_lbuf", 64'(wt_lbuf), 64'd0);
    check("rst_cpl_err", 64'(cpl_err), 64'd0);
    check("rst_data_rdy", 64'(data_rdy), 64'd0);

    // four zero-length lbufs queue up; rr starts at 0 -> grants 0,1,2,3
    ack_delay = 5;
    for (int c = 0; c < 4; c++) push_gc(c, 64'h1000_0000_0000_0000 + 64'(c * 16));
    for (int c = 0; c < 4; c++) arm(c, 64'h1000_0000_0000_0000 + 64'(c * 16), 32'd0);
    wait_updt(2, "wait_gnt_ch2");
    arm(2, 64'hDEAD_BEEF, 32'd0);
    wait_idle("arb_idle");
    ack_delay = 0;

    // 4096 bytes = 1024 DW as 32 x 32 DW; update two cycles after the last cpl
    push_gc(0, 64'h0000_0001_2345_6780);
    arm(0, 64'h0000_0001_2345_6780, 32'h1000);
    for (int k = 0; k < 31; k++) cpl(0, 10'd32);
    check("lat_early_updt", 64'(gc_updt), 64'd0);
    cpl(0, 10'd32);
    check("lat_plus1_updt", 64'(gc_updt), 64'd0);
    @(negedge clk);
    check("lat_plus2_updt", 64'(gc_updt), 64'd1);
    check("lat_plus2_ch", 64'(gc_ch), 64'd0);
    wait_idle("single_idle");
    check("single_err", 64'(cpl_err), 64'd0);

    // 6 bytes -> 2 DW: exact fill is clean, overshoot flags cpl_err
    push_gc(1, 64'hAAAA_0000);
    arm(1, 64'hAAAA_0000, 32'd6);
    cpl(1, 10'd2);
    wait_idle("exact_idle");
    check("exact_err", 64'(cpl_err), 64'd0);
    push_gc(2, 64'hBBBB_0000);
    arm(2, 64'hBBBB_0000, 32'd6);
    cpl(2, 10'd3);
    wait_idle("over_idle");
    check("over_err", 64'(cpl_err), 64'b0100);

    // cpl_dws=0 means 1024 DW; a cpl on idle ch3 only flags an error
    push_gc(1, 64'hCCCC_0000);
    arm(1, 64'hCCCC_0000, 32'd4096);
    cpl(1, 10'd0);
    cpl(3, 10'd5);
    wait_idle("dws0_idle");
    check("dws0_idle_err", 64'(cpl_err), 64'b1100);

    // async reset while gc_updt is held
    ack_delay = 100000;
    arm(3, 64'hEEEE_0000, 32'd0);
    wait_updt(3, "wait_rst_updt");
    check("pre_rst_updt", 64'(gc_updt), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_updt", 64'(gc_updt), 64'd0);
    check("async_rst_ch", 64'(gc_ch), 64'd0);
    check("async_rst_addr", gc_addr, 64'd0);
    check("async_rst_err", 64'(cpl_err), 64'd0);
    exp_q.delete();
    wexp_q.delete();
    ack_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_gc(1, 64'h5555_0000);
    arm(1, 64'h5555_0000, 32'd4);
    cpl(1, 10'd1);
    wait_idle("rearm_idle");
    check("rearm_err", 64'(cpl_err), 64'd0);

`ifdef COL_IRQ_EN
    // three closes in quick succession -> one pulse now, one after the hold
    repeat (100) @(negedge clk);
    dr_cnt = 0;
    for (int c = 0; c < 3; c++) push_gc(c, 64'(c));
    for (int c = 0; c < 3; c++) arm(c, 64'(c), 32'd0);
    repeat (27) @(negedge clk);
    check("irq_first", 64'(dr_cnt), 64'd1);
    repeat (80) @(negedge clk);
    check("irq_second", 64'(dr_cnt), 64'd2);
`else
    check("irq_never", 64'(dr_cnt), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
